obi_bus_arbiter: RTL and testbench
==================================

Name: obi_bus_arbiter

Overview:
- Shares one OBI-style slave bus (req/gnt/rvalid, single outstanding transaction) between NUM_REQ masters, e.g. the CPU instruction port, the CPU data port and a future DMA.
- Replaces the two-way inline arbiter in the SoC top. It adds round-robin fairness, a per-transaction response timeout with an error response, and a saturating timeout counter for debug.
- Sits between the masters and the SoC address decoder / peripheral mux.

Parameters:
- NUM_REQ, 2, number of masters (2..8).
- ADDR_WIDTH, 32, address width.
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority, lowest index wins.
- TIMEOUT_CYCLES, 64, cycles allowed from grant to rvalid; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- m_req_i  in  NUM_REQ  per-master request
- m_gnt_o  out  NUM_REQ  per-master grant, one-hot or zero
- m_rvalid_o  out  NUM_REQ  per-master response valid, one-hot or zero
- m_err_o  out  NUM_REQ  per-master error, qualified by m_rvalid_o
- m_addr_i  in  NUM_REQ*ADDR_WIDTH  flattened addresses; master k occupies slice k
- m_we_i  in  NUM_REQ  write enables
- m_be_i  in  NUM_REQ*4  byte enables
- m_wdata_i  in  NUM_REQ*32  write data
- m_rdata_o  out  32  read data, shared by all masters
- slv_req_o  out  1  slave request
- slv_gnt_i  in  1  slave grant
- slv_rvalid_i  in  1  slave response valid
- slv_addr_o  out  ADDR_WIDTH  slave address
- slv_we_o  out  1  slave write enable
- slv_be_o  out  4  slave byte enables
- slv_wdata_o  out  32  slave write data
- slv_rdata_i  in  32  slave read data
- busy_o  out  1  high whenever state != IDLE
- timeout_cnt_o  out  8  saturating count of timeouts

Behaviour:
- Clocking and reset:
  - One clock, clk_i; reset rst_ni is asynchronous, active-low.
  - On reset, regardless of the current state: state=IDLE, owner=0, last_grant=NUM_REQ-1 (so master 0 wins first), timer=0, timeout_cnt_o=0.
  - All combinational outputs then evaluate to 0.
- IDLE:
  - slv_req_o=0; slave address/control/data outputs are driven 0.
  - If any m_req_i bit is set, register the winner into owner and go to ADDR.
  - ROUND_ROBIN=1: winner is the first requesting index scanning from last_grant+1 modulo NUM_REQ.
  - ROUND_ROBIN=0: winner is the lowest requesting index.
  - The arbitration decision costs exactly 1 cycle.
- ADDR:
  - slv_req_o = m_req_i[owner]; slave address/we/be/wdata are muxed from master owner.
  - On slv_req_o && slv_gnt_i: m_gnt_o[owner]=1 in the same cycle, timer cleared, go to RESP.
  - If m_req_i[owner] drops before grant (a protocol violation): return to IDLE with no grant; last_grant is unchanged.
- RESP:
  - slv_req_o=0; timer increments every cycle.
  - On slv_rvalid_i: m_rvalid_o[owner]=1, m_rdata_o=slv_rdata_i, m_err_o=0; last_grant<=owner; go to IDLE.
  - If TIMEOUT_CYCLES!=0, no rvalid has arrived, and timer==TIMEOUT_CYCLES-1: m_rvalid_o[owner]=1, m_err_o[owner]=1, m_rdata_o=ERR_RDATA (32'hBADC_0FFE); timeout_cnt_o increments, saturating at 255; last_grant<=owner; go to IDLE.
  - If rvalid arrives in the same cycle as the timeout, the real response wins and nothing is counted.
- Outside RESP:
  - slv_rvalid_i is ignored (no m_rvalid_o).
  - m_rdata_o=0.
- Minimum latency with a registered-gnt slave:
  - req at cycle 0, ADDR at cycle 1, gnt at cycle 2, rvalid at cycle 3, next arbitration at cycle 4.
- Invariants:
  - At most one m_gnt_o bit and one m_rvalid_o bit are set at a time.
  - Never more than one slave transaction is outstanding.

Decomposition:
- Package obi_arb_pkg holds:
  - arb_state_e {IDLE, ADDR, RESP};
  - ERR_RDATA;
  - a function that computes the index width from NUM_REQ.
- Sub-module obi_rr_pick is combinational. Inputs: req vector, last_grant, mode. Outputs: winner index and valid.

Test Plan:
- Single master 0 read: slave gnt 1 cycle after req, rvalid 1 cycle after gnt with rdata 32'h1234_5678 -> m_gnt_o=01 at cycle 2, m_rvalid_o=01 at cycle 3 with m_rdata_o=32'h1234_5678.
- Both masters requesting continuously, ROUND_ROBIN=1 -> grants alternate 0,1,0,1 over 4 transactions. With ROUND_ROBIN=0 -> master 0 receives all 4 grants.
- Master 1 write: addr 32'hF000_0000, be 4'hF, wdata 1 -> slv_* outputs show exactly those values during ADDR, and master 0 inputs are not visible on them.
- TIMEOUT_CYCLES=8, slave never sends rvalid -> m_rvalid_o[owner]=1 and m_err_o[owner]=1 at the 8th RESP cycle, with m_rdata_o=32'hBADC_0FFE and timeout_cnt_o=1. A late slv_rvalid_i in IDLE produces no m_rvalid_o.
- rst_ni asserted in RESP -> busy_o=0, all m_*_o=0 and timeout_cnt_o=0 immediately, without waiting for a clock edge. After release, master 0 wins first.
- 300 forced timeouts -> timeout_cnt_o saturates at 255.

Source files
------------

// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the OBI bus arbiter.
//   arb_state_e : arbiter FSM states
//   ERR_RDATA   : read data returned with a timeout error response
//   idx_width() : bit width needed to index NUM_REQ masters
package obi_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StResp
    } arb_state_e;

    localparam logic [31:0] ERR_RDATA = 32'hBADC_0FFE;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/obi_rr_pick.sv
// Combinational winner selection for the OBI arbiter.
// Ports:
//   req_i     : request vector, one bit per master
//   last_i    : index of the most recently served master
//   rr_mode_i : 1 = rotating priority starting after last_i, 0 = lowest index wins
//   idx_o     : winning master index (0 when nothing requests)
//   valid_o   : at least one master is requesting
module obi_rr_pick #(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = 1
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    input  logic              rr_mode_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              valid_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    // Scan candidates in priority order; the first requester found wins.
    always_comb begin
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (rr_mode_i) begin
                cand = IdxW'((32'(last_i) + i + 32'd1) % NumReq);
            end else begin
                cand = IdxW'(i);
            end
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/obi_bus_arbiter.sv
// Shares one OBI-style slave bus between NUM_REQ masters with a single
// outstanding transaction. Round-robin or fixed priority, per-transaction
// response timeout with an error response, saturating timeout counter.
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   m_req_i / m_gnt_o     : per-master request / grant (grant one-hot or zero)
//   m_rvalid_o / m_err_o  : per-master response valid / error (error qualified by rvalid)
//   m_addr_i, m_we_i, m_be_i, m_wdata_i : flattened per-master request payload
//   m_rdata_o             : read data shared by all masters
//   slv_*                 : single slave port towards the address decoder
//   busy_o                : arbiter is not idle
//   timeout_cnt_o         : saturating count of timed-out transactions
module obi_bus_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ROUND_ROBIN    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            m_req_i,
    output logic [NUM_REQ-1:0]            m_gnt_o,
    output logic [NUM_REQ-1:0]            m_rvalid_o,
    output logic [NUM_REQ-1:0]            m_err_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_REQ-1:0]            m_we_i,
    input  logic [NUM_REQ*4-1:0]          m_be_i,
    input  logic [NUM_REQ*32-1:0]         m_wdata_i,
    output logic [31:0]                   m_rdata_o,
    output logic                          slv_req_o,
    input  logic                          slv_gnt_i,
    input  logic                          slv_rvalid_i,
    output logic [ADDR_WIDTH-1:0]         slv_addr_o,
    output logic                          slv_we_o,
    output logic [3:0]                    slv_be_o,
    output logic [31:0]                   slv_wdata_o,
    input  logic [31:0]                   slv_rdata_i,
    output logic                          busy_o,
    output logic [7:0]                    timeout_cnt_o
);

    localparam int unsigned     IdxW     = idx_width(NUM_REQ);
    // Reset last_grant to the top index so master 0 wins the first round.
    localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_REQ - 1);
    localparam logic [31:0]     TimeoutLast =
        (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [31:0]     timer_q, timer_d;
    logic [7:0]      tcnt_q, tcnt_d;

    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic            owner_req;
    logic            slv_hs;
    logic            timeout_hit;

    obi_rr_pick #(
        .NumReq (NUM_REQ),
        .IdxW   (IdxW)
    ) u_pick (
        .req_i     (m_req_i),
        .last_i    (last_q),
        .rr_mode_i (ROUND_ROBIN != 0),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    assign owner_req = m_req_i[owner_q];
    assign slv_hs    = (state_q == StAddr) && owner_req && slv_gnt_i;
    // A real response in the same cycle takes precedence over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == StResp) &&
                         !slv_rvalid_i && (timer_q == TimeoutLast);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= LastInit;
            timer_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        timer_d = timer_q;
        tcnt_d  = tcnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (!owner_req) begin
                    // Request withdrawn before grant: abandon without updating last_grant.
                    state_d = StIdle;
                end else if (slv_gnt_i) begin
                    timer_d = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                timer_d = timer_q + 32'd1;
                if (slv_rvalid_i) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                end else if (timeout_hit) begin
                    last_d  = owner_q;
                    state_d = StIdle;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        slv_req_o   = 1'b0;
        slv_addr_o  = '0;
        slv_we_o    = 1'b0;
        slv_be_o    = '0;
        slv_wdata_o = '0;
        m_gnt_o     = '0;
        m_rvalid_o  = '0;
        m_err_o     = '0;
        m_rdata_o   = '0;
        unique case (state_q)
            StAddr: begin
                slv_req_o   = owner_req;
                slv_addr_o  = m_addr_i[owner_q*ADDR_WIDTH +: ADDR_WIDTH];
                slv_we_o    = m_we_i[owner_q];
                slv_be_o    = m_be_i[owner_q*4 +: 4];
                slv_wdata_o = m_wdata_i[owner_q*32 +: 32];
                if (slv_hs) begin
                    m_gnt_o[owner_q] = 1'b1;
                end
            end
            StResp: begin
                if (slv_rvalid_i) begin
                    m_rvalid_o[owner_q] = 1'b1;
                    m_rdata_o           = slv_rdata_i;
                end else if (timeout_hit) begin
                    m_rvalid_o[owner_q] = 1'b1;
                    m_err_o[owner_q]    = 1'b1;
                    m_rdata_o           = ERR_RDATA;
                end
            end
            default: ;
        endcase
    end

    assign busy_o        = (state_q != StIdle);
    assign timeout_cnt_o = tcnt_q;

    a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(m_gnt_o));
    a_rvalid_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                      $onehot0(m_rvalid_o));
    a_owner_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    32'(owner_q) < NUM_REQ);

endmodule

// File: tb/tb_obi_bus_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance share
// all inputs; the slave side is driven by hand, cycle by cycle.
module tb_obi_bus_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  m_req = '0;
    logic [63:0] m_addr = '0;
    logic [1:0]  m_we = '0;
    logic [7:0]  m_be = '0;
    logic [63:0] m_wdata = '0;
    logic        slv_gnt = 1'b0;
    logic        slv_rvalid = 1'b0;
    logic [31:0] slv_rdata = '0;

    logic [1:0]  rr_gnt, rr_rvalid, rr_err;
    logic [31:0] rr_rdata, rr_slv_addr, rr_slv_wdata;
    logic        rr_slv_req, rr_slv_we, rr_busy;
    logic [3:0]  rr_slv_be;
    logic [7:0]  rr_tcnt;

    logic [1:0]  fp_gnt, fp_rvalid, fp_err;
    logic [31:0] fp_rdata, fp_slv_addr, fp_slv_wdata;
    logic        fp_slv_req, fp_slv_we, fp_busy;
    logic [3:0]  fp_slv_be;
    logic [7:0]  fp_tcnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    obi_bus_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)
    ) dut_rr (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_gnt_o(rr_gnt), .m_rvalid_o(rr_rvalid), .m_err_o(rr_err),
        .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_rdata_o(rr_rdata),
        .slv_req_o(rr_slv_req), .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid),
        .slv_addr_o(rr_slv_addr), .slv_we_o(rr_slv_we), .slv_be_o(rr_slv_be),
        .slv_wdata_o(rr_slv_wdata), .slv_rdata_i(slv_rdata),
        .busy_o(rr_busy), .timeout_cnt_o(rr_tcnt)
    );

    obi_bus_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(8)
    ) dut_fp (
        .clk_i(clk), .rst_ni(rst_n),
        .m_req_i(m_req), .m_gnt_o(fp_gnt), .m_rvalid_o(fp_rvalid), .m_err_o(fp_err),
        .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_rdata_o(fp_rdata),
        .slv_req_o(fp_slv_req), .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid),
        .slv_addr_o(fp_slv_addr), .slv_we_o(fp_slv_we), .slv_be_o(fp_slv_be),
        .slv_wdata_o(fp_slv_wdata), .slv_rdata_i(slv_rdata),
        .busy_o(fp_busy), .timeout_cnt_o(fp_tcnt)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        m_req = '0; slv_gnt = 1'b0; slv_rvalid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        total_cnt++; if (rr_busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", rr_busy);
        else pass_cnt++;
        total_cnt++; if (rr_slv_req !== 1'b0) $display("FAIL reset_slv_req: got %0b want 0",
                                                       rr_slv_req); else pass_cnt++;
        total_cnt++; if (rr_tcnt !== 8'd0) $display("FAIL reset_tcnt: got %0d want 0", rr_tcnt);
        else pass_cnt++;
        total_cnt++; if (rr_gnt !== 2'b00 || rr_rvalid !== 2'b00)
            $display("FAIL reset_gnt_rvalid: got %b/%b want 00/00", rr_gnt, rr_rvalid);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        m_req = 2'b01; m_addr[31:0] = 32'h0000_1000; m_be[3:0] = 4'hF;
        #1;  // cycle 0: idle
        total_cnt++; if (rr_busy !== 1'b0 || rr_slv_req !== 1'b0)
            $display("FAIL rd_c0_idle: got busy=%0b req=%0b want 0/0", rr_busy, rr_slv_req);
        else pass_cnt++;
        tick(); #1;  // cycle 1: address phase
        total_cnt++; if (rr_slv_req !== 1'b1 || rr_gnt !== 2'b00 || rr_slv_addr !== 32'h1000)
            $display("FAIL rd_c1_addr: got req=%0b gnt=%b addr=%h want 1/00/00001000",
                     rr_slv_req, rr_gnt, rr_slv_addr);
        else pass_cnt++;
        tick(); slv_gnt = 1'b1; #1;  // cycle 2: slave grants
        total_cnt++; if (rr_gnt !== 2'b01 || fp_gnt !== 2'b01)
            $display("FAIL rd_c2_gnt: got rr=%b fp=%b want 01", rr_gnt, fp_gnt);
        else pass_cnt++;
        tick(); slv_gnt = 1'b0; m_req = 2'b00; slv_rvalid = 1'b1; slv_rdata = 32'h1234_5678;
        #1;  // cycle 3: response
        total_cnt++; if (rr_rvalid !== 2'b01 || rr_err !== 2'b00 || rr_rdata !== 32'h1234_5678)
            $display("FAIL rd_c3_resp: got rv=%b err=%b rdata=%h want 01/00/12345678",
                     rr_rvalid, rr_err, rr_rdata);
        else pass_cnt++;
        tick(); slv_rvalid = 1'b0; #1;  // cycle 4: idle again
        total_cnt++; if (rr_busy !== 1'b0 || rr_rdata !== 32'd0)
            $display("FAIL rd_c4_idle: got busy=%0b rdata=%h want 0/0", rr_busy, rr_rdata);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rr;
        apply_reset();
        m_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_rr = (t % 2 == 0) ? 2'b01 : 2'b10;
            tick();                      // address phase
            tick(); slv_gnt = 1'b1; #1;  // grant
            total_cnt++; if (rr_gnt !== exp_rr)
                $display("FAIL rr_gnt[%0d]: got %b want %b", t, rr_gnt, exp_rr);
            else pass_cnt++;
            total_cnt++; if (fp_gnt !== 2'b01)
                $display("FAIL fp_gnt[%0d]: got %b want 01", t, fp_gnt);
            else pass_cnt++;
            tick(); slv_gnt = 1'b0; slv_rvalid = 1'b1; slv_rdata = 32'(t); #1;
            total_cnt++; if (rr_rvalid !== exp_rr)
                $display("FAIL rr_rvalid[%0d]: got %b want %b", t, rr_rvalid, exp_rr);
            else pass_cnt++;
            tick(); slv_rvalid = 1'b0;
        end
        m_req = 2'b00;
        tick();
    endtask

    task automatic test_write_mux();
        apply_reset();
        m_addr  = {32'hF000_0000, 32'h1111_1111};
        m_be    = {4'hF, 4'h3};
        m_wdata = {32'h0000_0001, 32'hAAAA_5555};
        m_we    = 2'b10;
        m_req   = 2'b10;
        #1;
        total_cnt++; if (rr_slv_addr !== 32'd0 || rr_slv_wdata !== 32'd0)
            $display("FAIL wr_idle_zero: got addr=%h wdata=%h want 0/0", rr_slv_addr,
                     rr_slv_wdata);
        else pass_cnt++;
        tick(); #1;
        total_cnt++; if (rr_slv_addr !== 32'hF000_0000 || rr_slv_we !== 1'b1 ||
                         rr_slv_be !== 4'hF || rr_slv_wdata !== 32'h1 || rr_slv_req !== 1'b1)
            $display("FAIL wr_addr_mux: got addr=%h we=%0b be=%h wdata=%h req=%0b want f0000000/1/f/00000001/1",
                     rr_slv_addr, rr_slv_we, rr_slv_be, rr_slv_wdata, rr_slv_req);
        else pass_cnt++;
        total_cnt++; if (fp_slv_addr !== 32'hF000_0000 || fp_slv_be !== 4'hF)
            $display("FAIL wr_fp_mux: got addr=%h be=%h want f0000000/f", fp_slv_addr, fp_slv_be);
        else pass_cnt++;
        tick(); slv_gnt = 1'b1; #1;
        total_cnt++; if (rr_gnt !== 2'b10)
            $display("FAIL wr_gnt: got %b want 10", rr_gnt);
        else pass_cnt++;
        tick(); slv_gnt = 1'b0; m_req = 2'b00; slv_rvalid = 1'b1; #1;
        total_cnt++; if (rr_rvalid !== 2'b10)
            $display("FAIL wr_rvalid: got %b want 10", rr_rvalid);
        else pass_cnt++;
        tick(); slv_rvalid = 1'b0;
        m_addr = '0; m_be = '0; m_wdata = '0; m_we = '0;
    endtask

    // Takes the bus from idle up to the first response cycle for master 0.
    task automatic start_m0_txn();
        m_req = 2'b01;
        tick();
        tick(); slv_gnt = 1'b1;
        tick(); slv_gnt = 1'b0; m_req = 2'b00;
    endtask

    task automatic test_timeout();
        int early;
        apply_reset();
        start_m0_txn();
        early = 0;
        for (int i = 1; i <= 7; i++) begin
            #1;
            if (rr_rvalid !== 2'b00) early++;
            tick();
        end
        #1;
        total_cnt++; if (early !== 0)
            $display("FAIL to_early: got %0d early responses want 0", early);
        else pass_cnt++;
        total_cnt++; if (rr_rvalid !== 2'b01 || rr_err !== 2'b01 || rr_rdata !== 32'hBADC_0FFE)
            $display("FAIL to_resp: got rv=%b err=%b rdata=%h want 01/01/badc0ffe",
                     rr_rvalid, rr_err, rr_rdata);
        else pass_cnt++;
        total_cnt++; if (rr_tcnt !== 8'd0)
            $display("FAIL to_cnt_before: got %0d want 0", rr_tcnt);
        else pass_cnt++;
        tick(); slv_rvalid = 1'b1; #1;
        total_cnt++; if (rr_tcnt !== 8'd1 || rr_busy !== 1'b0)
            $display("FAIL to_cnt_after: got cnt=%0d busy=%0b want 1/0", rr_tcnt, rr_busy);
        else pass_cnt++;
        total_cnt++; if (rr_rvalid !== 2'b00)
            $display("FAIL to_late_rvalid: got %b want 00", rr_rvalid);
        else pass_cnt++;
        slv_rvalid = 1'b0;
        tick();
    endtask

    task automatic test_timeout_race();
        start_m0_txn();
        repeat (7) tick();
        slv_rvalid = 1'b1; slv_rdata = 32'hCAFE_F00D; #1;
        total_cnt++; if (rr_rvalid !== 2'b01 || rr_err !== 2'b00 || rr_rdata !== 32'hCAFE_F00D)
            $display("FAIL race_resp: got rv=%b err=%b rdata=%h want 01/00/cafef00d",
                     rr_rvalid, rr_err, rr_rdata);
        else pass_cnt++;
        tick(); slv_rvalid = 1'b0; #1;
        total_cnt++; if (rr_tcnt !== 8'd1)
            $display("FAIL race_cnt: got %0d want 1", rr_tcnt);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_in_resp();
        start_m0_txn();
        slv_rvalid = 1'b1; slv_rdata = 32'h0000_0005; #1;
        total_cnt++; if (rr_rvalid !== 2'b01 || rr_tcnt !== 8'd1)
            $display("FAIL rst_pre: got rv=%b cnt=%0d want 01/1", rr_rvalid, rr_tcnt);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++; if (rr_busy !== 1'b0 || rr_rvalid !== 2'b00 || rr_gnt !== 2'b00 ||
                         rr_err !== 2'b00 || rr_rdata !== 32'd0 || rr_slv_req !== 1'b0)
            $display("FAIL rst_async_out: got busy=%0b rv=%b gnt=%b err=%b rdata=%h want all 0",
                     rr_busy, rr_rvalid, rr_gnt, rr_err, rr_rdata);
        else pass_cnt++;
        total_cnt++; if (rr_tcnt !== 8'd0)
            $display("FAIL rst_async_cnt: got %0d want 0", rr_tcnt);
        else pass_cnt++;
        slv_rvalid = 1'b0; m_req = 2'b11;
        #2 rst_n = 1'b1;
        tick();
        tick(); slv_gnt = 1'b1; #1;
        total_cnt++; if (rr_gnt !== 2'b01)
            $display("FAIL rst_first_winner: got %b want 01", rr_gnt);
        else pass_cnt++;
        tick(); slv_gnt = 1'b0; m_req = 2'b00; slv_rvalid = 1'b1;
        tick(); slv_rvalid = 1'b0;
    endtask

    task automatic test_saturation();
        int errs;
        int cyc;
        bit mid_pending;
        apply_reset();
        errs = 0; cyc = 0; mid_pending = 1'b0;
        m_req = 2'b01; slv_gnt = 1'b1;
        while (errs < 300 && cyc < 4000) begin
            tick(); #1;
            cyc++;
            if (mid_pending) begin
                mid_pending = 1'b0;
                total_cnt++; if (rr_tcnt !== 8'd100)
                    $display("FAIL sat_mid: got %0d want 100", rr_tcnt);
                else pass_cnt++;
            end
            if (rr_err[0] === 1'b1) begin
                errs++;
                if (errs == 100) mid_pending = 1'b1;
            end
        end
        m_req = 2'b00; slv_gnt = 1'b0;
        total_cnt++; if (errs !== 300)
            $display("FAIL sat_budget: got %0d timeouts want 300", errs);
        else pass_cnt++;
        tick(); #1;
        total_cnt++; if (rr_tcnt !== 8'd255 || fp_tcnt !== 8'd255)
            $display("FAIL sat_final: got rr=%0d fp=%0d want 255", rr_tcnt, fp_tcnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_mux();
        test_timeout();
        test_timeout_race();
        test_reset_in_resp();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
